// File: rtl/mseq_pkg.sv
// rtl/mseq_pkg.sv - shared constants, FSM state codes and helpers for the m-sequence controller
package mseq_pkg;

    // Default LFSR width and the configuration loaded at reset.
    localparam int               MSEQ_W        = 5;
    localparam logic [MSEQ_W-1:0] MSEQ_DEF_POLY = 5'b11101;
    localparam logic [MSEQ_W-1:0] MSEQ_DEF_SEED = 5'b10101;

    // Controller FSM state codes.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Full period of a maximal-length sequence for a w-bit register.
    function automatic int mseq_nb(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/mseq_step.sv
// rtl/mseq_step.sv - one combinational LFSR step: next state and output chip
//
// Ports:
//   state_i  current LFSR state (fase)
//   poly_i   feedback tap mask (type_f)
//   next_o   state after one step: shift left, feedback parity into bit 0
//   chip_o   chip for the current state (state MSB)
module mseq_step #(
    parameter int W = 5
) (
    input  logic [W-1:0] state_i,
    input  logic [W-1:0] poly_i,
    output logic [W-1:0] next_o,
    output logic         chip_o
);

    assign next_o = {state_i[W-2:0], ^(state_i & poly_i)};
    assign chip_o = state_i[W-1];

endmodule

// File: rtl/mseq_ctrl.sv
// rtl/mseq_ctrl.sv - run controller sequencing the m-sequence LFSR chip by chip
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_we_i/cfg_poly_i/cfg_seed_i  poly/seed load, honoured only in IDLE
//   start_i, abort_i, len_i       run control; len 0 means a full period
//   chip_o/chip_valid_o/chip_ready_i  chip stream handshake
//   busy_o, done_o, err_o         status; done is a one-cycle pulse
//   word_out_o                    chips packed in arrival order, newest at bit 0
//   period_out_o                  first step count that returned to the seed
module mseq_ctrl
    import mseq_pkg::*;
#(
    parameter int           W        = MSEQ_W,
    parameter logic [W-1:0] DEF_POLY = MSEQ_DEF_POLY,
    parameter logic [W-1:0] DEF_SEED = MSEQ_DEF_SEED
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we_i,
    input  logic [W-1:0]            cfg_poly_i,
    input  logic [W-1:0]            cfg_seed_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [W-1:0]            len_i,
    output logic                    chip_o,
    output logic                    chip_valid_o,
    input  logic                    chip_ready_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [mseq_nb(W)-1:0]   word_out_o,
    output logic [W-1:0]            period_out_o
);

    localparam int NB = mseq_nb(W);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  poly_q, poly_d;
    logic [W-1:0]  seed_q, seed_d;
    logic [W-1:0]  lfsr_q, lfsr_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  len_q, len_d;
    logic [NB-1:0] word_q, word_d;
    logic [W-1:0]  period_q, period_d;
    logic          err_q, err_d;

    logic [W-1:0]  step_next;
    logic          step_chip;
    logic [W-1:0]  start_seed;
    logic [W-1:0]  target;

    mseq_step #(.W(W)) u_step (
        .state_i (lfsr_q),
        .poly_i  (poly_q),
        .next_o  (step_next),
        .chip_o  (step_chip)
    );

    // A start in the same cycle as a config write runs with the new seed.
    assign start_seed = cfg_we_i ? cfg_seed_i : seed_q;
    assign target     = (len_q == '0) ? W'(NB) : len_q;

    always_comb begin
        state_d  = state_q;
        poly_d   = poly_q;
        seed_d   = seed_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        word_d   = word_q;
        period_d = period_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_we_i) begin
                    poly_d = cfg_poly_i;
                    seed_d = cfg_seed_i;
                end
                if (start_i) begin
                    lfsr_d   = start_seed;
                    cnt_d    = '0;
                    len_d    = len_i;
                    word_d   = '0;
                    period_d = '0;
                    err_d    = (start_seed == '0);
                    // A zero seed would lock the LFSR at zero, so skip straight to DONE.
                    state_d  = (start_seed == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort wins over a same-cycle handshake; that chip is dropped.
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (chip_ready_i) begin
                    lfsr_d = step_next;
                    cnt_d  = cnt_q + 1'b1;
                    word_d = {word_q[NB-2:0], step_chip};
                    if (step_next == seed_q && period_q == '0) begin
                        period_d = cnt_q + 1'b1;
                    end
                    if (cnt_q == target - 1'b1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            poly_q   <= DEF_POLY;
            seed_q   <= DEF_SEED;
            lfsr_q   <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            word_q   <= '0;
            period_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            poly_q   <= poly_d;
            seed_q   <= seed_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            word_q   <= word_d;
            period_q <= period_d;
            err_q    <= err_d;
        end
    end

    assign chip_o       = step_chip;
    assign chip_valid_o = (state_q == ST_RUN);
    assign busy_o       = (state_q == ST_RUN);
    assign done_o       = (state_q == ST_DONE);
    assign err_o        = err_q;
    assign word_out_o   = word_q;
    assign period_out_o = period_q;

endmodule

// File: tb/tb_mseq_ctrl.sv
// tb/tb_mseq_ctrl.sv - randomized self-checking bench for mseq_ctrl against a behavioural model
module tb_mseq_ctrl;

    localparam int W  = 5;
    localparam int NB = 31;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we_i;
    logic [W-1:0]  cfg_poly_i;
    logic [W-1:0]  cfg_seed_i;
    logic          start_i;
    logic          abort_i;
    logic [W-1:0]  len_i;
    logic          chip_o;
    logic          chip_valid_o;
    logic          chip_ready_i;
    logic          busy_o;
    logic          done_o;
    logic          err_o;
    logic [NB-1:0] word_out_o;
    logic [W-1:0]  period_out_o;

    mseq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we_i     (cfg_we_i),
        .cfg_poly_i   (cfg_poly_i),
        .cfg_seed_i   (cfg_seed_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .len_i        (len_i),
        .chip_o       (chip_o),
        .chip_valid_o (chip_valid_o),
        .chip_ready_i (chip_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .word_out_o   (word_out_o),
        .period_out_o (period_out_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model of the DUT's configuration registers.
    int cur_poly;
    int cur_seed;

    // Expected chip k, and word/period after k accepted chips.
    int exp_chip [0:NB];
    longint exp_word [0:NB];
    int exp_per  [0:NB];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sequence rule: shift left by one (doubling mod 2^W), feedback = parity of tapped bits.
    function automatic int model_step(input int s, input int p);
        return ((s * 2) % 32) + ($countones(s & p) % 2);
    endfunction

    task automatic build_model(input int poly, input int seed, input int n);
        int s;
        longint w;
        int per;
        s = seed; w = 0; per = 0;
        exp_word[0] = 0; exp_per[0] = 0;
        for (int i = 0; i < n; i++) begin
            exp_chip[i] = s / 16;
            w = (w * 2 + exp_chip[i]) % (64'd1 << NB);
            s = model_step(s, poly);
            if (s == seed && per == 0) per = i + 1;
            exp_word[i+1] = w;
            exp_per[i+1]  = per;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        cur_poly = 5'b11101;
        cur_seed = 5'b10101;
    endtask

    // Entered and left at a falling edge.
    task automatic run(input string tag, input bit cfg_now, input bit cfg_same,
                       input int poly, input int seed, input int len,
                       input int ready_pct, input int abort_at,
                       input int stall_at, input int stall_n, input bit noise);
        int n, hs, stalls, left, used_seed;
        bit fin, aborted, hs_pend;
        if (cfg_now && !cfg_same) begin
            cfg_we_i = 1'b1; cfg_poly_i = poly[W-1:0]; cfg_seed_i = seed[W-1:0];
            @(negedge clk);
            cfg_we_i = 1'b0;
        end
        if (cfg_now) begin cur_poly = poly; cur_seed = seed; end
        used_seed = cur_seed;
        n = (len == 0) ? NB : len;
        if (used_seed == 0) n = 0;
        build_model(cur_poly, used_seed, n);
        start_i = 1'b1; len_i = len[W-1:0];
        cfg_we_i = cfg_now && cfg_same;
        cfg_poly_i = poly[W-1:0]; cfg_seed_i = seed[W-1:0];
        @(negedge clk);
        start_i = 1'b0; cfg_we_i = 1'b0;
        len_i = W'($urandom);
        hs = 0; stalls = 0; left = stall_n; fin = 0; aborted = 0;
        for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
            hs_pend = 1'b0;
            if (done_o) begin
                check({tag, " done_cycle"}, 64'(cyc), 64'(n + stalls + 1));
                check({tag, " chip_count"}, 64'(hs), 64'(n));
                check({tag, " busy_in_done"}, 64'(busy_o), 64'(0));
                check({tag, " valid_in_done"}, 64'(chip_valid_o), 64'(0));
                check({tag, " word"}, 64'(word_out_o), 64'(exp_word[hs]));
                check({tag, " period"}, 64'(period_out_o), 64'(exp_per[hs]));
                check({tag, " err"}, 64'(err_o), 64'(used_seed == 0));
                fin = 1;
            end else if (chip_valid_o) begin
                check($sformatf("%s chip%0d", tag, hs), 64'(chip_o), 64'(exp_chip[hs]));
                check({tag, " busy_in_run"}, 64'(busy_o), 64'(1));
                if (hs == abort_at) begin
                    abort_i = 1'b1; chip_ready_i = 1'b1; aborted = 1;
                end else if (hs == stall_at && left > 0) begin
                    left--; stalls++;
                end else if ($urandom_range(0, 99) < ready_pct) begin
                    chip_ready_i = 1'b1; hs_pend = 1'b1;
                end else begin
                    stalls++;
                end
                if (noise && $urandom_range(0, 3) == 0) begin
                    start_i = 1'b1; cfg_we_i = 1'b1;
                    cfg_poly_i = W'($urandom); cfg_seed_i = W'($urandom);
                end
            end else if (aborted) begin
                check({tag, " abort_busy"}, 64'(busy_o), 64'(0));
                check({tag, " abort_word"}, 64'(word_out_o), 64'(exp_word[hs]));
                check({tag, " abort_period"}, 64'(period_out_o), 64'(exp_per[hs]));
                fin = 1;
            end else begin
                check({tag, " stream_state"}, 64'(1), 64'(0));
                fin = 1;
            end
            @(negedge clk);
            if (hs_pend) hs++;
            start_i = 1'b0; cfg_we_i = 1'b0; abort_i = 1'b0; chip_ready_i = 1'b0;
        end
        if (!fin) check({tag, " timeout"}, 64'(0), 64'(1));
        check({tag, " done_after"}, 64'(done_o), 64'(0));
        check({tag, " busy_after"}, 64'(busy_o), 64'(0));
    endtask

    initial begin
        cfg_we_i = 0; cfg_poly_i = 0; cfg_seed_i = 0; start_i = 0; abort_i = 0;
        len_i = 0; chip_ready_i = 0;
        cur_poly = 0; cur_seed = 0;
        @(negedge clk);
        do_reset();
        check("rst chip_valid", 64'(chip_valid_o), 64'(0));
        check("rst busy", 64'(busy_o), 64'(0));
        check("rst done", 64'(done_o), 64'(0));
        check("rst err", 64'(err_o), 64'(0));
        check("rst word", 64'(word_out_o), 64'(0));
        check("rst period", 64'(period_out_o), 64'(0));

        run("full",    0, 0, 0,        0,        0, 100, -1, -1, 0, 0);
        check("full period31", 64'(exp_per[NB]), 64'(31));
        run("short",   1, 0, 5'b10000, 5'b10101, 0, 100, -1, -1, 0, 0);
        run("stall",   1, 0, 5'b11101, 5'b10101, 0, 100, -1,  7, 3, 0);
        run("len5",    0, 0, 0,        0,        5, 100, -1, -1, 0, 0);
        run("zseed",   1, 0, 5'b11101, 5'b00000, 0, 100, -1, -1, 0, 0);
        run("abort10", 1, 1, 5'b11101, 5'b10101, 0, 100, 10, -1, 0, 0);
        run("same",    1, 1, 5'b10111, 5'b00011, 0,  70, -1, -1, 0, 1);

        // Reset in the middle of a run brings back the default configuration.
        cfg_we_i = 1; cfg_poly_i = 5'b10000; cfg_seed_i = 5'b00001;
        start_i = 1; len_i = 0;
        @(negedge clk);
        cfg_we_i = 0; start_i = 0; chip_ready_i = 1;
        repeat (6) @(negedge clk);
        chip_ready_i = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst valid", 64'(chip_valid_o), 64'(0));
        check("midrst busy", 64'(busy_o), 64'(0));
        check("midrst done", 64'(done_o), 64'(0));
        check("midrst err", 64'(err_o), 64'(0));
        check("midrst word", 64'(word_out_o), 64'(0));
        check("midrst period", 64'(period_out_o), 64'(0));
        cur_poly = 5'b11101; cur_seed = 5'b10101;
        run("postrst", 0, 0, 0, 0, 0, 100, -1, -1, 0, 0);

        for (int r = 0; r < 10; r++) begin
            int p, s, l, a;
            p = $urandom_range(1, 31);
            s = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
            l = $urandom_range(0, 31);
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : -1;
            run($sformatf("rnd%0d", r), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                p, s, l, $urandom_range(40, 100), a, -1, 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
